// File: rtl/moravec_pkg.sv
// Shared definitions for the Moravec window generator slice.
//   PIX_W        default pixel width
//   NB_*         neighbour slot indices, clockwise from north-west
//   N_DIR        number of neighbour directions (one per downstream cell)
//   state_e      handshake FSM states
package moravec_pkg;

  localparam int PIX_W = 8;
  localparam int N_DIR = 8;

  localparam int NB_NW = 0;
  localparam int NB_N  = 1;
  localparam int NB_NE = 2;
  localparam int NB_E  = 3;
  localparam int NB_SE = 4;
  localparam int NB_S  = 5;
  localparam int NB_SW = 6;
  localparam int NB_W  = 7;

  typedef enum logic {
    ACCEPT = 1'b0,
    HOLD   = 1'b1
  } state_e;

endpackage

// File: rtl/moravec_line_buf.sv
// Circular delay line holding exactly one image row.
// Every push returns the value pushed DEPTH pushes earlier (read happens
// before the write into the same slot).
//   clk   clock, all logic on posedge
//   rst   synchronous active-high reset (pointer only, storage is not cleared)
//   push  advance the delay line by one sample
//   din   sample written on push
//   dout  sample stored DEPTH pushes ago, valid whenever push is high
module moravec_line_buf
  import moravec_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Pointer wraps explicitly so DEPTH need not be a power of two.
  always_comb begin
    ptr_d = ptr_q;
    if (push) begin
      ptr_d = (ptr_q == PTR_MAX) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptr_q] <= din;
    end
  end

  assign dout = mem[ptr_q];

endmodule

// File: rtl/moravec_window_gen.sv
// Raster-to-3x3 window feeder for the Moravec corner cell chain.
// Accepts one pixel every two clocks, keeps two row delay lines and the two
// most recent window columns, and for each interior centre presents the
// centre plus its 8 neighbours for two cycles.
//   clk, rst    clock and synchronous active-high reset
//   in_valid    pixel offered
//   in_ready    pixel can be taken this cycle
//   in_pixel    raster-order pixel value
//   in_sof      accepted pixel is (0,0) of a new frame
//   win_valid   window outputs valid (drives every cell's start)
//   win_center  centre pixel
//   win_nb      neighbours, slice k = direction k clockwise from NW
//   win_row     centre row
//   win_col     centre column
//   win_last    window centred at (IMG_H-2, IMG_W-2)
module moravec_window_gen
  import moravec_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = moravec_pkg::PIX_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PIX_W-1:0]           in_pixel,
  input  logic                       in_sof,
  output logic                       win_valid,
  output logic [PIX_W-1:0]           win_center,
  output logic [N_DIR*PIX_W-1:0]     win_nb,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       win_last
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);

  state_e state_q;
  state_e state_d;
  logic   accept;
  logic   emit;

  logic [ROW_W-1:0] row_q, row_d, row_cur;
  logic [COL_W-1:0] col_q, col_d, col_cur;

  logic [PIX_W-1:0] lb1_out;
  logic [PIX_W-1:0] lb2_out;

  // west_col holds column c-2 and mid_col column c-1 relative to the pixel
  // being accepted; index 0 is the top row of the window.
  logic [PIX_W-1:0] west_col_q [3];
  logic [PIX_W-1:0] west_col_d [3];
  logic [PIX_W-1:0] mid_col_q  [3];
  logic [PIX_W-1:0] mid_col_d  [3];

  logic                   win_valid_q, win_valid_d;
  logic                   win_age_q, win_age_d;
  logic                   win_last_q, win_last_d;
  logic [PIX_W-1:0]       win_center_q, win_center_d;
  logic [N_DIR*PIX_W-1:0] win_nb_q, win_nb_d;
  logic [ROW_W-1:0]       win_row_q, win_row_d;
  logic [COL_W-1:0]       win_col_q, win_col_d;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCEPT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: every accept is followed by exactly one non-ready cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCEPT:  if (in_valid) state_d = HOLD;
      HOLD:    state_d = ACCEPT;
      default: state_d = ACCEPT;
    endcase
  end

  // Ready is gated by rst so it reads low for the whole reset period.
  always_comb begin
    in_ready = (state_q == ACCEPT) && !rst;
  end

  assign accept = in_valid && in_ready;

  // in_sof forces the accepted pixel to (0,0) before the position advances.
  always_comb begin
    row_cur = in_sof ? '0 : row_q;
    col_cur = in_sof ? '0 : col_q;
    row_d   = row_q;
    col_d   = col_q;
    if (accept) begin
      if (col_cur == COL_MAX) begin
        col_d = '0;
        row_d = (row_cur == ROW_MAX) ? '0 : row_cur + ROW_W'(1);
      end else begin
        col_d = col_cur + COL_W'(1);
        row_d = row_cur;
      end
    end
  end

  assign emit = accept && (row_cur >= ROW_W'(2)) && (col_cur >= COL_W'(2));

  moravec_line_buf #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb1 (
    .clk  (clk),
    .rst  (rst),
    .push (accept),
    .din  (in_pixel),
    .dout (lb1_out)
  );

  moravec_line_buf #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb2 (
    .clk  (clk),
    .rst  (rst),
    .push (accept),
    .din  (lb1_out),
    .dout (lb2_out)
  );

  // Window shift plus output capture. The outputs are loaded from the
  // pre-shift columns and the incoming column so they appear one cycle
  // after the emitting accept.
  always_comb begin
    west_col_d   = west_col_q;
    mid_col_d    = mid_col_q;
    win_valid_d  = win_valid_q;
    win_age_d    = win_age_q;
    win_last_d   = win_last_q;
    win_center_d = win_center_q;
    win_nb_d     = win_nb_q;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;

    if (accept) begin
      west_col_d   = mid_col_q;
      mid_col_d[0] = lb2_out;
      mid_col_d[1] = lb1_out;
      mid_col_d[2] = in_pixel;
    end

    if (emit) begin
      win_valid_d  = 1'b1;
      win_age_d    = 1'b0;
      win_last_d   = (row_cur == ROW_MAX) && (col_cur == COL_MAX);
      win_center_d = mid_col_q[1];
      win_nb_d[NB_NW*PIX_W +: PIX_W] = west_col_q[0];
      win_nb_d[NB_N *PIX_W +: PIX_W] = mid_col_q[0];
      win_nb_d[NB_NE*PIX_W +: PIX_W] = lb2_out;
      win_nb_d[NB_E *PIX_W +: PIX_W] = lb1_out;
      win_nb_d[NB_SE*PIX_W +: PIX_W] = in_pixel;
      win_nb_d[NB_S *PIX_W +: PIX_W] = mid_col_q[2];
      win_nb_d[NB_SW*PIX_W +: PIX_W] = west_col_q[2];
      win_nb_d[NB_W *PIX_W +: PIX_W] = west_col_q[1];
      win_row_d    = row_cur - ROW_W'(1);
      win_col_d    = col_cur - COL_W'(1);
    end else if (win_valid_q) begin
      // Two-cycle hold so each alternate-phase cell sees one active phase.
      if (!win_age_q) begin
        win_age_d = 1'b1;
      end else begin
        win_valid_d = 1'b0;
        win_last_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    west_col_q <= west_col_d;
    mid_col_q  <= mid_col_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q        <= '0;
      col_q        <= '0;
      win_valid_q  <= 1'b0;
      win_age_q    <= 1'b0;
      win_last_q   <= 1'b0;
      win_center_q <= '0;
      win_nb_q     <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      win_valid_q  <= win_valid_d;
      win_age_q    <= win_age_d;
      win_last_q   <= win_last_d;
      win_center_q <= win_center_d;
      win_nb_q     <= win_nb_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
    end
  end

  assign win_valid  = win_valid_q;
  assign win_last   = win_last_q;
  assign win_center = win_center_q;
  assign win_nb     = win_nb_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;

endmodule

// File: tb/tb_moravec_window_gen.sv
// Self-checking bench for moravec_window_gen on a 4x4 image.
// A position-tracking image model predicts every window; a negedge monitor
// records the windows the block actually presents and how long each lasts.
module tb_moravec_window_gen;

  localparam int IMG_W = 4;
  localparam int IMG_H = 4;

  typedef struct packed {
    logic [7:0]  center;
    logic [63:0] nb;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        last;
  } win_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pixel;
  logic        in_sof;
  logic        win_valid;
  logic [7:0]  win_center;
  logic [63:0] win_nb;
  logic [1:0]  win_row;
  logic [1:0]  win_col;
  logic        win_last;

  int checks = 0;
  int errors = 0;

  moravec_window_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .PIX_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .in_sof     (in_sof),
    .win_valid  (win_valid),
    .win_center (win_center),
    .win_nb     (win_nb),
    .win_row    (win_row),
    .win_col    (win_col),
    .win_last   (win_last)
  );

  always #5 clk = ~clk;

  // Image model: the frame as a 2D array plus the current raster position.
  logic [7:0] img [IMG_H][IMG_W];
  int mr = 0;
  int mc = 0;
  int dr [8] = '{-1, -1, -1, 0, 1, 1, 1, 0};
  int dc [8] = '{-1, 0, 1, 1, 1, 0, -1, -1};
  win_t exp_q [$];

  // Monitor state.
  win_t obs_q [$];
  int   obs_dur [$];
  bit   obs_contig [$];
  bit   prev_valid = 1'b0;
  bit   prev_rst   = 1'b1;
  bit   prev_acc   = 1'b0;
  bit   prev_ready = 1'b0;
  win_t prev_win   = '0;
  int   ready_viol = 0;
  int   hold_viol  = 0;
  int   last_viol  = 0;
  int   idle_chg   = 0;

  always @(negedge clk) begin
    win_t cur;
    cur = '{center: win_center, nb: win_nb, row: win_row, col: win_col, last: win_last};
    if (win_valid === 1'b1) begin
      if (!prev_valid || cur !== prev_win) begin
        obs_q.push_back(cur);
        obs_dur.push_back(1);
        obs_contig.push_back(prev_valid);
      end else begin
        obs_dur[obs_dur.size()-1] += 1;
      end
    end
    if (win_last === 1'b1 && win_valid !== 1'b1) last_viol++;
    if (win_valid !== 1'b1 && !prev_valid && !rst && !prev_rst && cur !== prev_win) idle_chg++;
    if (prev_acc && in_ready !== 1'b0) ready_viol++;
    if (!rst && !prev_rst && !prev_ready && in_ready !== 1'b1) hold_viol++;
    prev_acc   = (in_valid === 1'b1) && (in_ready === 1'b1);
    prev_ready = (in_ready === 1'b1);
    prev_valid = (win_valid === 1'b1);
    prev_rst   = rst;
    prev_win   = cur;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_dur.delete();
    obs_contig.delete();
    exp_q.delete();
    ready_viol = 0;
    hold_viol  = 0;
    last_viol  = 0;
    idle_chg   = 0;
  endtask

  task automatic model_accept(input logic [7:0] pix, input logic sof);
    win_t w;
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = pix;
    if (mr >= 2 && mc >= 2) begin
      w.center = img[mr-1][mc-1];
      for (int k = 0; k < 8; k++) w.nb[k*8 +: 8] = img[mr-1+dr[k]][mc-1+dc[k]];
      w.row  = 2'(mr - 1);
      w.col  = 2'(mc - 1);
      w.last = (mr == IMG_H-1) && (mc == IMG_W-1);
      exp_q.push_back(w);
    end
    if (mc == IMG_W-1) begin
      mc = 0;
      mr = (mr == IMG_H-1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  // Called at posedge+1; leaves in_valid high so a gap-free caller keeps it
  // asserted through the non-ready cycle.
  task automatic feed(input logic [7:0] pix, input logic sof, input int gap);
    int waited;
    if (gap > 0) idle(gap);
    in_valid = 1'b1;
    in_pixel = pix;
    in_sof   = sof;
    waited   = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL handshake: in_ready=%b after %0d cycles, required 1", in_ready, waited);
    end else begin
      model_accept(pix, sof);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_pixel = '0; in_sof = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("[TB] FAIL rst_ready: got %b want 0", in_ready); end
    checks++; if (win_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b want 0", win_valid); end
    checks++; if (win_last !== 1'b0)  begin errors++; $display("[TB] FAIL rst_last: got %b want 0", win_last); end
    checks++; if (win_center !== 8'd0) begin errors++; $display("[TB] FAIL rst_center: got %h want 0", win_center); end
    checks++; if (win_nb !== 64'd0)   begin errors++; $display("[TB] FAIL rst_nb: got %h want 0", win_nb); end
    checks++; if (win_row !== 2'd0 || win_col !== 2'd0) begin
      errors++; $display("[TB] FAIL rst_rowcol: got %0d,%0d want 0,0", win_row, win_col);
    end
    sync();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_ready: got %b want 1", in_ready); end
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1 || win_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_idle: ready=%b valid=%b want 1,0", in_ready, win_valid);
    end
  endtask

  task automatic test_basic_frame();
    win_t got, want;
    int   n_last;
    sync();
    clear_obs();
    for (int p = 0; p < 16; p++) feed(8'(p), p == 0, 0);
    idle(6);
    checks++; if (obs_q.size() != 4) begin errors++; $display("[TB] FAIL basic_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : '0;
      checks++; if (got !== exp_q[i]) begin errors++; $display("[TB] FAIL basic_win%0d: got %h want %h", i, got, exp_q[i]); end
      checks++; if (i >= obs_dur.size() || obs_dur[i] != 2) begin
        errors++; $display("[TB] FAIL basic_dur%0d: got %0d want 2", i, (i < obs_dur.size()) ? obs_dur[i] : 0);
      end
    end
    want = '{center: 8'd5, nb: {8'd4, 8'd8, 8'd9, 8'd10, 8'd6, 8'd2, 8'd1, 8'd0}, row: 2'd1, col: 2'd1, last: 1'b0};
    got  = (obs_q.size() > 0) ? obs_q[0] : '0;
    checks++; if (got !== want) begin errors++; $display("[TB] FAIL basic_first: got %h want %h", got, want); end
    got = (obs_q.size() > 3) ? obs_q[3] : '0;
    checks++; if (got.center !== 8'd10 || got.last !== 1'b1 || got.row !== 2'd2 || got.col !== 2'd2) begin
      errors++; $display("[TB] FAIL basic_lastwin: got c=%0d last=%b r=%0d c=%0d want 10,1,2,2", got.center, got.last, got.row, got.col);
    end
    n_last = 0;
    foreach (obs_q[i]) if (obs_q[i].last) n_last++;
    checks++; if (n_last != 1) begin errors++; $display("[TB] FAIL basic_nlast: got %0d want 1", n_last); end
    checks++; if (obs_contig.size() < 2 || obs_contig[1] != 1'b1) begin
      errors++; $display("[TB] FAIL basic_contig: got %0d want 1", (obs_contig.size() > 1) ? obs_contig[1] : 0);
    end
    checks++; if (ready_viol != 0 || hold_viol != 0) begin
      errors++; $display("[TB] FAIL basic_ready_alt: got %0d/%0d bad cycles want 0", ready_viol, hold_viol);
    end
    checks++; if (last_viol != 0) begin errors++; $display("[TB] FAIL basic_last_timing: got %0d want 0", last_viol); end
  endtask

  task automatic test_random_gaps();
    win_t got;
    sync();
    clear_obs();
    for (int p = 0; p < 32; p++) feed(8'($urandom), p == 0, int'($urandom_range(0, 3)));
    idle(6);
    checks++; if (obs_q.size() != 8) begin errors++; $display("[TB] FAIL rand_count: got %0d want 8", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : '0;
      checks++; if (got !== exp_q[i]) begin errors++; $display("[TB] FAIL rand_win%0d: got %h want %h", i, got, exp_q[i]); end
      checks++; if (i >= obs_dur.size() || obs_dur[i] != 2) begin
        errors++; $display("[TB] FAIL rand_dur%0d: got %0d want 2", i, (i < obs_dur.size()) ? obs_dur[i] : 0);
      end
    end
    checks++; if (idle_chg != 0) begin errors++; $display("[TB] FAIL rand_stall_hold: got %0d changes want 0", idle_chg); end
    checks++; if (ready_viol != 0 || hold_viol != 0 || last_viol != 0) begin
      errors++; $display("[TB] FAIL rand_protocol: got %0d/%0d/%0d want 0", ready_viol, hold_viol, last_viol);
    end
  endtask

  task automatic test_rst_midframe();
    win_t got;
    sync();
    clear_obs();
    for (int p = 0; p <= 10; p++) feed(8'(p), p == 0, 0);
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ready: got %b want 0", in_ready); end
    sync();
    @(negedge clk);
    checks++; if (win_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_outs: valid=%b ready=%b want 0,0", win_valid, in_ready);
    end
    checks++; if (win_center !== 8'd0 || win_last !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_clear: center=%h last=%b want 0,0", win_center, win_last);
    end
    checks++; if (obs_dur.size() != 1 || obs_dur[0] != 1) begin
      errors++; $display("[TB] FAIL midrst_drop: got %0d windows dur %0d want 1 window dur 1", obs_dur.size(), (obs_dur.size() > 0) ? obs_dur[0] : 0);
    end
    sync();
    rst = 1'b0;
    clear_obs();
    for (int p = 0; p < 16; p++) feed(8'(p), p == 0, 0);
    idle(6);
    checks++; if (obs_q.size() != 4) begin errors++; $display("[TB] FAIL restart_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : '0;
      checks++; if (got !== exp_q[i]) begin errors++; $display("[TB] FAIL restart_win%0d: got %h want %h", i, got, exp_q[i]); end
    end
    got = (obs_q.size() > 0) ? obs_q[0] : '0;
    checks++; if (got.center !== 8'd5) begin errors++; $display("[TB] FAIL restart_first: got %0d want 5", got.center); end
  endtask

  task automatic test_sof_midrow();
    win_t got;
    sync();
    clear_obs();
    for (int p = 0; p < 9; p++) feed(8'($urandom), p == 0, int'($urandom_range(0, 1)));
    for (int p = 0; p < 16; p++) feed(8'($urandom), p == 0, int'($urandom_range(0, 1)));
    idle(6);
    checks++; if (obs_q.size() != 4) begin errors++; $display("[TB] FAIL sof_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : '0;
      checks++; if (got !== exp_q[i]) begin errors++; $display("[TB] FAIL sof_win%0d: got %h want %h", i, got, exp_q[i]); end
    end
    got = (obs_q.size() > 0) ? obs_q[0] : '0;
    checks++; if (got.row !== 2'd1 || got.col !== 2'd1) begin
      errors++; $display("[TB] FAIL sof_first_pos: got %0d,%0d want 1,1", got.row, got.col);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_random_gaps();
    test_rst_midframe();
    test_sof_midrow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/moravec_window_gen.md
# moravec_window_gen

Upstream feeder for the Moravec corner stage. Accepts a raster pixel stream and maintains two line buffers plus a 3x3 shift window. For every interior pixel it presents the centre pixel and its 8 neighbours to the chain of 8 `MoravecFF` cells, which consume `inCenter`/`inTarget`/`start`. Windows are paced at one per two clocks, which matches the cells' alternate-cycle evaluation.

## Interface
Parameters:
- `IMG_W`, 64, image width in pixels (≥3)
- `IMG_H`, 64, image height in rows (≥3)
- `PIX_W`, 8, pixel width (`moravec_pkg::PIX_W`)

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  pixel present
- `in_ready`  out  1  block can accept this cycle
- `in_pixel`  in  PIX_W  pixel value, raster order
- `in_sof`  in  1  qualifies accepted pixel as (row 0, col 0)
- `win_valid`  out  1  window outputs valid; drives every cell's `start`
- `win_center`  out  PIX_W  centre pixel; drives every `inCenter`
- `win_nb`  out  8*PIX_W  neighbours; slice k drives cell k `inTarget`
- `win_row`  out  $clog2(IMG_H)  centre row
- `win_col`  out  $clog2(IMG_W)  centre column
- `win_last`  out  1  window centred at (IMG_H-2, IMG_W-2)

## Operation
- Neighbour slice order, clockwise from NW: 0=NW, 1=N, 2=NE, 3=E, 4=SE, 5=S, 6=SW, 7=W.
- FSM states:
  - ACCEPT: `in_ready`=1. On `in_valid`, the pixel is accepted and the FSM goes to HOLD.
  - HOLD: `in_ready`=0. Always returns to ACCEPT next cycle.
  - Every accept is followed by exactly one non-ready cycle, border pixels included.
- On accept of pixel (r,c):
  - Shift window columns left.
  - New right column = {line buffer 2 out, line buffer 1 out, `in_pixel`}, top to bottom.
  - Push line buffer 1 output into line buffer 2, and `in_pixel` into line buffer 1.
  - Advance `col`. On `col`=IMG_W-1, `col` wraps to 0 and `row` increments. On `row`=IMG_H-1 and `col`=IMG_W-1, both wrap to 0.
- Window emission: accept with r≥2 and c≥2 yields window centred at (r-1, c-1).
- Accepts with r<2 or c<2 only update storage; `win_valid` stays 0.
- `in_sof` on an accepted pixel forces that pixel to (0,0) before the counter update. The pixel is stored normally.
  - Line buffers are not cleared on `in_sof`; stale data is never emitted because windows need r≥2.
- No `in_sof` at frame end: counters wrap and the next frame proceeds identically.
- Window outputs are registered and hold until the next emitting accept.

## Timing
- Reset values: `in_ready`=0 while `rst`=1 and ACCEPT afterwards; `win_valid`=0, `win_last`=0, `win_center`=0, `win_nb`=0, `win_row`=0, `win_col`=0; counters 0.
- Line buffer RAM contents are not reset.
- Emitting accept at cycle T:
  - Window outputs valid at T+1 and T+2.
  - `win_valid`=1 for exactly those two cycles.
  - If T+2 is itself an emitting accept, the new window appears at T+3 and `win_valid` stays high continuously.
- The two-cycle hold guarantees exactly one active phase of each downstream flip-flopped cell, whatever its phase.
- `win_last` has the same timing as `win_valid` for its window.
- Maximum throughput is 1 pixel per 2 clocks. `in_valid` low in ACCEPT stalls without state change.
- `rst` mid-frame:
  - FSM returns to ACCEPT, counters go to 0, and window outputs are cleared next cycle.
  - A window in its hold period is dropped.
- `in_sof` and counter wrap in the same accept: `in_sof` wins.

## Structure
- `moravec_pkg`:
  - `PIX_W`
  - `NB_NW`..`NB_W` index constants (0..7)
  - `N_DIR`=8
  - FSM state enum {ACCEPT, HOLD}
- Sub-module `moravec_line_buf`:
  - IMG_W-deep, PIX_W-wide circular delay line.
  - Single pointer; read-before-write on push enable.
  - Instantiated twice.
- Top holds the FSM, counters, 3x3 register window and output registers.

## Test plan
- IMG_W=IMG_H=4, pixel=r*4+c, `in_sof` on first, `in_valid` held high:
  - first window after accepting (2,2)=10: center=5, nb={0,1,2,6,10,9,8,4}, row=1, col=1;
  - exactly 4 windows total; `win_last` only on the (2,2) window, center=10.
- Same stream: `in_ready` alternates 1,0; each window's `win_valid` lasts 2 cycles; consecutive windows (1,1)→(1,2) keep `win_valid` high continuously.
- Random `in_valid` gaps: window contents and sequence identical to the gap-free run. A stall in ACCEPT produces no output change beyond the 2-cycle hold.
- `rst` asserted one cycle after a window emission:
  - `win_valid`=0 and `in_ready`=0 during reset;
  - after a full restarted frame with `in_sof`, output matches the first test.
- `in_sof` mid-row (row 2, col 1) of a 4x4 frame: counters restart; no window emitted until new row 2, col 2.
- Cascade of 8 `MoravecFF` fed by the block, first cell `inE`=14'h3FFF, image with a single 200-valued pixel at (2,2) on 0 background:
  - center-(1,1) window reports minimum 0;
  - the window centred on (2,2) reports minimum 200²=40000 truncated per the cell's width rules.
